bcd2bin_seq: RTL and testbench
==============================

Name: bcd2bin_seq

Overview:
- Sequential BCD-to-binary converter using reverse double-dabble (shift right, subtract 3).
- Converts packed BCD digits from the settings/entry path (player-entered thresholds, target times) into a binary value for the game's comparators and counters.
- Start/busy/done handshake; one bit of result per clock.

Parameters:
- NDIG, 3, number of BCD digits on bcd_in; most significant digit is in the top nibble.
- BW, 10, binary output width; must satisfy 2^BW > 10^NDIG - 1; also the shift count.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  conversion request; sampled only in IDLE.
- bcd_in  input  4*NDIG  packed BCD operand; captured on the accepting edge.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse when bin/err are updated.
- err  output  1  last conversion rejected (a nibble > 9); held until next accepted start.
- bin  output  BW  converted value; held until the next done.

Behaviour:
- One clock, clk. rst_n is asynchronous and active-low: assertion forces state IDLE immediately, regardless of clk.
- Reset values: busy=0, done=0, err=0, bin=0, internal shift register=0, counter=0.
- Internal register: sr of width 4*NDIG+BW. The BCD field is the upper 4*NDIG bits; the binary field is the lower BW bits.
- Counter: cnt, width ceil(log2(BW+1)).
- States: IDLE, SHIFT, DONE.
- IDLE, start=0: stay in IDLE.
- IDLE, start=1, every nibble of bcd_in <= 9:
  - Load sr = {bcd_in, BW'b0}, cnt=0, clear err.
  - Go to SHIFT.
- IDLE, start=1, any nibble > 9:
  - No conversion. bin=0, err=1.
  - Go to DONE.
- SHIFT, each cycle, as one combinational step registered on the edge:
  - sr shifted right by 1 (zero fill at MSB).
  - Then every 4-bit BCD field of the shifted value that is >= 8 has 3 subtracted.
  - cnt increments by 1.
- SHIFT, when cnt reaches BW-1: that edge performs the final step, writes bin = lower BW bits of the post-step sr, and goes to DONE.
- DONE: done=1 for exactly this one cycle; go to IDLE unconditionally on the next edge.
- Latency: start accepted at edge E0 -> BW shift edges E1..E_BW -> done high in the cycle following E_BW. With BW=10, done is high 11 cycles after the accepting edge.
  - Error path: done is high in the cycle after E0.
- busy is high exactly during the BW SHIFT cycles. It is low in IDLE and DONE.
- Ignored starts:
  - start while in SHIFT or DONE is ignored, not queued.
  - start held high continuously re-triggers from IDLE, so back-to-back conversions run every BW+2 cycles.
- Input stability: bcd_in may change freely after the accepting edge; only the captured copy is used.
- Arithmetic: digit corrections are 4-bit and never underflow, since a field is >= 8 when corrected. No overflow is possible given the BW constraint.
- Reset mid-conversion:
  - Abort immediately; outputs go to reset values.
  - The partial result is discarded; no done pulse.
- Output stability: bin and err change only on the edge entering DONE (or on reset).

Test Plan:
- Reset, then bcd_in=12'h999, start for 1 cycle:
  - busy high for 10 cycles.
  - done pulse 11 cycles after the start edge.
  - bin=10'd999 (0x3E7), err=0.
- bcd_in=12'h000 -> bin=0, err=0. bcd_in=12'h255 -> bin=255. bcd_in=12'h100 -> bin=100.
- Invalid operand, bcd_in=12'h1A3:
  - done on the next cycle after start; bin=0, err=1, busy never high.
  - A following valid start with 12'h042 clears err and gives bin=42.
- start pulsed again 4 cycles into a conversion of 12'h512:
  - Ignored; a single done with bin=512.
  - bcd_in changed to 12'h777 mid-conversion has no effect on the result.
- rst_n asserted asynchronously 5 cycles into a conversion of 12'h321:
  - busy, done, err, bin drop to 0 without a clock edge.
  - After release, no done pulse occurs until a new start.
- start held high continuously with bcd_in=12'h050:
  - done pulses every 12 cycles, each with bin=50.

Source files
------------

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble): one binary bit per clock,
// start/busy/done handshake, err flags operands with a nibble above 9.
`timescale 1ns/1ps

module bcd2bin_seq_dig (
  input  logic [3:0] shf,
  input  logic [3:0] cap,
  output logic [3:0] fix,
  output logic       bad
);
  // A shifted digit >= 8 had a half-ten carried in from above; subtracting 3 re-normalises it.
  assign fix = (shf >= 4'd8) ? (shf - 4'd3) : shf;
  assign bad = (cap > 4'd9);
endmodule

module bcd2bin_seq #(
  parameter int NDIG = 3,
  parameter int BW   = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [4*NDIG-1:0] bcd_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [BW-1:0]     bin
);
  localparam int SRW = 4*NDIG + BW;
  localparam int CW  = $clog2(BW+1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state_q, state_d;
  logic [SRW-1:0]  sr_q, sr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   bin_q, bin_d;
  logic            err_q, err_d;

  logic [SRW-1:0]             shf, step;
  logic [NDIG-1:0][3:0]       fix;
  logic [NDIG-1:0]            bad;

  assign shf = sr_q >> 1;

  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    bcd2bin_seq_dig u_dig (
      .shf (shf[BW+4*g +: 4]),
      .cap (bcd_in[4*g +: 4]),
      .fix (fix[g]),
      .bad (bad[g])
    );
  end

  assign step = {fix, shf[BW-1:0]};

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (|bad) begin
            bin_d   = '0;
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            sr_d    = {bcd_in, {BW{1'b0}}};
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        sr_d  = step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(BW-1)) begin
          bin_d   = step[BW-1:0];
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign err  = err_q;
  assign bin  = bin_q;
endmodule

// File: tb/tb_bcd2bin_seq.sv
// Randomised and directed bench for bcd2bin_seq against a decimal-arithmetic reference model.
`timescale 1ns/1ps

module tb_bcd2bin_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] bcd_in = '0;
  logic        busy, done, err;
  logic [9:0]  bin;

  int n_vec = 0;
  int n_err = 0;

  bcd2bin_seq #(.NDIG(3), .BW(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bcd_in(bcd_in),
    .busy(busy), .done(done), .err(err), .bin(bin)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Decimal value of the digits, or err when any digit is not 0..9.
  task automatic ref_model(input logic [11:0] b, output int val, output logic e);
    logic [11:0] t;
    int d;
    t = b; val = 0; e = 1'b0;
    for (int i = 2; i >= 0; i--) begin
      d = int'((t >> (4*i)) & 12'hF);
      if (d > 9) e = 1'b1;
      val = val*10 + d;
    end
    if (e) val = 0;
  endtask

  task automatic do_conv(input logic [11:0] b);
    int k, nbusy, ev;
    logic ee;
    ref_model(b, ev, ee);
    @(negedge clk); start = 1'b1; bcd_in = b;
    @(posedge clk); #1 start = 1'b0; bcd_in = 12'($urandom);
    k = 0; nbusy = 0;
    do begin
      @(negedge clk); k++;
      if (busy) nbusy++;
    end while (!done && k < 40);
    chk("latency", k, ee ? 1 : 11);
    chk("busy_cycles", nbusy, ee ? 0 : 10);
    chk("bin", int'(bin), ev);
    chk("err", int'(err), int'(ee));
    @(negedge clk);
    chk("done_pulse", int'(done), 0);
  endtask

  function automatic logic [11:0] rand_bcd(input bit valid);
    logic [11:0] r;
    r = 12'($urandom);
    if (valid)
      for (int i = 0; i < 3; i++) r[4*i +: 4] = 4'($urandom_range(9, 0));
    return r;
  endfunction

  initial begin
    int ndone, ev, last, first;
    logic ee;
    logic [9:0] seen;

    #12;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err",  int'(err), 0);
    chk("rst_bin",  int'(bin), 0);
    @(negedge clk); rst_n = 1'b1;

    do_conv(12'h999);
    do_conv(12'h000);
    do_conv(12'h255);
    do_conv(12'h100);
    do_conv(12'h1A3);
    do_conv(12'h042);

    // Start re-pulsed mid-conversion with a different operand must be ignored.
    @(negedge clk); start = 1'b1; bcd_in = 12'h512;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; bcd_in = 12'h777;
    @(negedge clk); start = 1'b0;
    ndone = 0; seen = '0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) begin ndone++; seen = bin; end
    end
    chk("ignored_start_dones", ndone, 1);
    chk("ignored_start_bin", int'(seen), 512);

    // Asynchronous reset partway into a conversion.
    @(negedge clk); start = 1'b1; bcd_in = 12'h321;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_busy", int'(busy), 0);
    chk("async_done", int'(done), 0);
    chk("async_err",  int'(err), 0);
    chk("async_bin",  int'(bin), 0);
    @(negedge clk); rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("post_reset_quiet", ndone, 0);

    // start held high: a conversion every BW+2 cycles.
    @(negedge clk); start = 1'b1; bcd_in = 12'h050;
    ndone = 0; last = -1; first = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        chk("held_bin", int'(bin), 50);
        if (!first) chk("held_period", i - last, 12);
        first = 0; last = i;
      end
    end
    start = 1'b0;
    chk("held_dones", ndone, 3);
    repeat (14) @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      do_conv(rand_bcd($urandom_range(3, 0) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1);
  end
endmodule
